bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning the binary input width; the legal range is 4..13, so the maximum value is 8191 and it fits in four BCD digits.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge of clk.
REQ-005 The block SHALL have port bin_in, input, N bits: unsigned binary value, captured when start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse indicating the outputs now hold a new result.
REQ-008 The block SHALL have ports bcd_un, bcd_dec, bcd_cent and bcd_mil, each output, 4 bits: the registered units, tens, hundreds and thousands digits, intended to feed the downstream 7-segment decoder directly.

Function
REQ-009 The block SHALL implement the states IDLE and SHIFT, using a shift-and-add-3 (double dabble) algorithm, one bit per clock.
REQ-010 In IDLE with start=1 at edge t0, the block SHALL:
- capture bin_in into the shift register;
- clear the 16-bit BCD scratch register;
- load the bit counter with N;
- enter SHIFT and set busy=1 at t0.
REQ-011 In IDLE with start=0, the block SHALL hold the state, the outputs and the scratch register unchanged.
REQ-012 Each cycle in SHIFT, the block SHALL add 3 to every scratch digit that is >=5, using the pre-shift values.
REQ-013 In the same cycle, the block SHALL then shift {scratch, binary} left by one bit and decrement the counter.
REQ-014 The add-3 correction SHALL be applied per nibble, with no carry between nibbles.
REQ-015 On the edge performing the N-th shift (t0+N), the block SHALL:
- load the final scratch digits into bcd_un, bcd_dec, bcd_cent and bcd_mil;
- set done=1 and busy=0;
- return to IDLE.
REQ-016 The latency SHALL be N clock cycles from the accepting edge to the result; done SHALL be high only in the cycle following edge t0+N.
REQ-017 The outputs bcd_* SHALL hold the last result until the next done and SHALL never show intermediate scratch values.
REQ-018 A start asserted while busy=1 SHALL be ignored and not queued, and bin_in changes during SHIFT SHALL have no effect.
REQ-019 A start in the cycle where done=1 (the state is already IDLE) SHALL be accepted, giving back-to-back conversions with one idle cycle minimum between accepting edges of N+1 cycles.
REQ-020 A start held high continuously SHALL restart a conversion at every IDLE cycle, producing a done every N+1 cycles.
REQ-021 Every output digit SHALL be in the range 0..9, and bcd_mil SHALL be <=8 for all legal N.

Reset
REQ-022 With rst=0, the block SHALL immediately, independent of clk, force the state to IDLE and busy=0, done=0, all bcd_* outputs=0, and the counter and scratch register to 0.
REQ-023 A reset asserted mid-conversion SHALL abort the conversion without producing a done, and the outputs SHALL read 0 afterwards.
REQ-024 After rst is released, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-025 With N=10 and bin_in=0: pulse start, then done at t0+10 with digits mil/cent/dec/un = 0/0/0/0, and busy high for exactly 10 cycles.
REQ-026 With N=10 and bin_in=1023: digits 1/0/2/3; with bin_in=999: digits 0/9/9/9; with bin_in=512: digits 0/5/1/2.
REQ-027 Start bin_in=345, then at t0+3 apply start with bin_in=678: result 0/3/4/5, exactly one done pulse, and the second start is ignored.
REQ-028 Hold start=1 with bin_in stepping 100, 200, 300: three done pulses spaced 11 cycles apart, with results 100, 200, 300 in order.
REQ-029 Start bin_in=777, then assert rst=0 at t0+5 mid-cycle: the outputs zero asynchronously, no done occurs, and a restart after release gives 0/7/7/7.
REQ-030 Apply 200 random bin_in values in 0..1023 and compare each digit against value/1000, (value/100)%10, (value/10)%10 and value%10; zero mismatches are required.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Latency: N cycles from the accepting edge to done; result registers hold until the next done.
// Backpressure: none; a start while busy is dropped, never queued.
module bin2bcd_seq #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bin_in,
  output logic         busy,
  output logic         done,
  output logic [3:0]   bcd_un,
  output logic [3:0]   bcd_dec,
  output logic [3:0]   bcd_cent,
  output logic [3:0]   bcd_mil
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] bin_q, bin_d;
  logic [15:0]  scr_q, scr_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [15:0]  out_q, out_d;
  logic         done_q, done_d;

  // Corrected scratch, bit 15 dropped: it is shifted out and is always 0 for N <= 13.
  logic [14:0]  corr;
  logic [15:0]  scr_shl;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      corr[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    end
    corr[14:12] = 3'((scr_q[15:12] >= 4'd5) ? scr_q[15:12] + 4'd3 : scr_q[15:12]);
    scr_shl     = {corr, bin_q[N-1]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = 4'(N);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shl;
        bin_d = {bin_q[N-2:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          out_d   = scr_shl;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd_un   = out_q[3:0];
  assign bcd_dec  = out_q[7:4];
  assign bcd_cent = out_q[11:8];
  assign bcd_mil  = out_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: scoreboard of expected values, monitor checks digits on every done.
module tb_bin2bcd_seq;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] bin_in;
  logic         busy;
  logic         done;
  logic [3:0]   bcd_un, bcd_dec, bcd_cent, bcd_mil;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_out = 0;
  int sb[$];

  bin2bcd_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done),
    .bcd_un(bcd_un), .bcd_dec(bcd_dec), .bcd_cent(bcd_cent), .bcd_mil(bcd_mil)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: decimal digits computed arithmetically from the queued value.
  always @(negedge clk) begin
    if (!rst) begin
      last_out = 0;
    end else if (done) begin
      done_cnt++;
      chk("busy_at_done", int'(busy), 0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got a done, expected none (t=%0t)", $time);
      end else begin
        int v;
        v = sb.pop_front();
        chk("mil",  int'(bcd_mil),  v / 1000);
        chk("cent", int'(bcd_cent), (v / 100) % 10);
        chk("dec",  int'(bcd_dec),  (v / 10) % 10);
        chk("un",   int'(bcd_un),   v % 10);
      end
      last_out = int'({bcd_mil, bcd_cent, bcd_dec, bcd_un});
    end else begin
      chk("hold", int'({bcd_mil, bcd_cent, bcd_dec, bcd_un}), last_out);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run(input int v, output int bc);
    bit seen;
    start  = 1'b1;
    bin_in = N'(v);
    sb.push_back(v);
    @(negedge clk);
    start  = 1'b0;
    bin_in = N'($urandom_range(0, 1023));
    bc   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done, expected one for %0d", v);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, d0, t[3];
    bit seen;
    rst = 1'b0; start = 1'b0; bin_in = '0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_digits", int'({bcd_mil, bcd_cent, bcd_dec, bcd_un}), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Zero input, busy duration, and first start after reset release.
    run(0, bc);
    chk("busy_cycles_0", bc, N);

    // Back-to-back directed values.
    run(1023, bc); chk("busy_cycles_1023", bc, N);
    run(999, bc);  chk("busy_cycles_999", bc, N);
    run(512, bc);  chk("busy_cycles_512", bc, N);
    repeat (3) @(negedge clk);

    // Start while busy is ignored.
    d0 = done_cnt;
    start = 1'b1; bin_in = N'(345); sb.push_back(345);
    @(negedge clk); start = 1'b0; bin_in = N'(111);
    @(negedge clk);
    @(negedge clk); start = 1'b1; bin_in = N'(678);
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    chk("ignored_start_dones", done_cnt - d0, 1);
    chk("ignored_start_queue", sb.size(), 0);

    // Start held high: done every N+1 cycles.
    start = 1'b1; bin_in = N'(100); sb.push_back(100);
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      if (!seen) begin
        n_cmp++; n_bad++;
        $display("FAIL held_start_timeout: got no done, expected done %0d", k);
      end
      t[k] = cyc;
      if (k < 2) begin
        bin_in = N'((k + 2) * 100);
        sb.push_back((k + 2) * 100);
      end
    end
    start = 1'b0;
    chk("held_spacing_1", t[1] - t[0], N + 1);
    chk("held_spacing_2", t[2] - t[1], N + 1);
    repeat (2) @(negedge clk);

    // Reset mid-conversion aborts and clears outputs asynchronously.
    start = 1'b1; bin_in = N'(777);
    @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_digits", int'({bcd_mil, bcd_cent, bcd_dec, bcd_un}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("abort_no_done", done_cnt - d0, 0);
    run(777, bc);
    chk("busy_cycles_777", bc, N);

    // Random values with occasional back-to-back starts.
    for (int r = 0; r < 200; r++) begin
      run($urandom_range(0, 1023), bc);
      if (bc != N) chk("busy_cycles_rand", bc, N);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (15) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
